data_ram_responder: RTL and testbench
=====================================

Name: data_ram_responder

Overview:
- Memory-side AXI4-Lite responder for the core's data port.
- Serves loads and stores that the memory stage issues into the data address space: default base 0x00001000, 4 KiB.
- Byte-strobed synchronous RAM with independent read and write channels and full valid/ready backpressure on every channel.
- Out-of-range accesses complete with an error response. No fabric-level decode is required.

Parameters:
- BASE, 32'h00001000, first byte address served (core::DATA_BASE).
- SIZE, 32'h00001000, bytes served (core::DATA_SIZE); power of two, ≥ 4.
- WORDS, SIZE/4, derived local parameter; RAM depth.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- awaddr  in  32  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data (core::word_t).
- wstrb  in  4  byte enables (core::strb_t); bit n enables wdata[8n+7:8n].
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response (core::resp_t).
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  32  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, named reset.
- Reset values: awready=1, wready=1, arready=1, bvalid=0, bresp=OKAY, rvalid=0, rresp=OKAY, rdata=0. RAM contents are not reset.
- Handshake: a transfer occurs on valid&&ready at a rising edge. Once outputs are valid, they hold stable until accepted.
- Write channel state: two one-entry holding registers, AW and W, each with a full flag.
  - awready = !aw_full; wready = !w_full.
  - AW and W are accepted independently, in either order or in the same cycle.
- Write commit: occurs in the cycle where both holding entries are full (or being filled that cycle) and (!bvalid || bready).
  - In-range: RAM word (addr-BASE)>>2 is written under wstrb. Bytes with a clear strobe are unchanged. wstrb=0 writes nothing and still returns OKAY.
  - On commit: both full flags clear; next cycle bvalid=1, with bresp=OKAY if in range, else SLVERR (2'b10) and no RAM write.
  - Steady-state throughput: one write per cycle while bready=1.
- Read channel: arready = !rvalid || rready.
  - On AR accept, the RAM is read. Next cycle rvalid=1 and rdata = word contents.
  - While rvalid && !rready, rdata and rresp hold. The RAM output is captured into an output register, not re-read.
  - Out of range: rresp=SLVERR, rdata=0.
  - Latency: 1 cycle. Back-to-back throughput: 1 per cycle when rready=1.
- Range check: BASE ≤ addr < BASE+SIZE, computed in 33 bits so BASE+SIZE=2^32 does not wrap. addr[1:0] is ignored for indexing.
- Simultaneous read and write to the same word in one cycle: read-first. rdata returns the pre-write value.
- Read and write channels are fully independent; neither blocks the other.
- Reset mid-transaction: all holding entries and pending responses are dropped, and ready/valid outputs return to their reset values the next cycle. RAM contents are retained.

Optional Feature:
- Macro: DATA_RAM_ALIGN_CHECK_EN.
- Defined: awaddr[1:0]≠0 or araddr[1:0]≠0 yields SLVERR. A misaligned write does not modify RAM; a misaligned read returns rdata=0.
- Undefined: low address bits are ignored; misaligned accesses behave as aligned accesses to the containing word.

Decomposition:
- Shared package core gains:
  - resp_t enum {OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11}.
  - an inrange(addr, base, size) helper function.
- Reused from core: word_t, strb_t, DATA_BASE, DATA_SIZE.
- Sub-module ram_sdp_bytewrite: simple dual-port RAM, one write port with per-byte enables and one synchronous read port, read-first, parameterized by depth. It is inferable as block RAM.

Test Plan:
- Same-cycle AW 0x1004 and W 0xDEADBEEF, strobe 4'hF, then read 0x1004 → bresp OKAY one cycle after commit; rdata 0xDEADBEEF with rresp OKAY one cycle after AR accept.
- Write 0x11223344 to 0x1008, then strobe 4'b0101 with 0xAABBCCDD → read 0x1008 returns 0x11BB33DD.
- W presented 3 cycles before AW; bready held low for 4 cycles → awready=0 and wready=0 while the previous response is pending; one RAM write only; bvalid stays high until bready.
- Write to 0x0FFC and 0x2000, read 0x2000 → SLVERR each; read rdata=0; contents of 0x1FFC unchanged.
- Back-to-back reads 0x1000, 0x1004, 0x1008 with rready toggling 1,0,1 → rdata stable while stalled; order preserved; arready tracks !rvalid||rready.
- Same-cycle read and write commit to 0x1010 (old value 0x1, new value 0x2) → rdata 0x1; a subsequent read returns 0x2. With DATA_RAM_ALIGN_CHECK_EN, a read of 0x1011 → SLVERR, rdata 0.

Source files
------------

// File: rtl/data_ram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_responder_pkg
// Description : Shared core types for the data-side memory responder:
//               word/strobe types, AXI response codes, the data address
//               window and an address range helper.
// Revision    : 1.0 - initial release
// ============================================================================
package data_ram_responder_pkg;

   typedef logic [31:0] word_t;
   typedef logic [3:0]  strb_t;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   localparam word_t DATA_BASE = 32'h0000_1000;
   localparam word_t DATA_SIZE = 32'h0000_1000;

   // Widened to 33 bits so a window ending at 2^32 does not wrap to zero.
   function automatic logic inrange(input word_t addr, input word_t base, input word_t size);
      logic [32:0] a;
      logic [32:0] lo;
      logic [32:0] hi;
      a  = {1'b0, addr};
      lo = {1'b0, base};
      hi = {1'b0, base} + {1'b0, size};
      return (a >= lo) && (a < hi);
   endfunction

endpackage
`default_nettype wire

// File: rtl/data_ram_responder_ram_sdp_bytewrite.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_responder_ram_sdp_bytewrite
// Description : Simple dual-port RAM, one byte-enabled write port and one
//               synchronous read port with enable. Read-first on collision.
//               The read register holds its value while re is low.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_responder_ram_sdp_bytewrite #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [3:0]    wbe,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   // Storage and read register share one process so a same-address
   // read and write returns the pre-write word.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
      for (int b = 0; b < 4; b++) begin
         if (we && wbe[b]) begin
            mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_responder
// Description : AXI4-Lite memory-side responder for the core data port.
//               Byte-strobed RAM with independent read/write channels,
//               one-entry AW and W holding registers, SLVERR outside the
//               BASE..BASE+SIZE window.
//               Optional: DATA_RAM_ALIGN_CHECK_EN makes misaligned
//               addresses return SLVERR (no write, read data zero).
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_responder
   import data_ram_responder_pkg::*;
#(
   parameter word_t BASE = DATA_BASE,
   parameter word_t SIZE = DATA_SIZE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready
);

   localparam int unsigned WORDS = SIZE / 4;
   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   // Write-side registers
   logic        aw_full_q, aw_full_d;
   word_t       aw_addr_q, aw_addr_d;
   logic        w_full_q,  w_full_d;
   word_t       w_data_q,  w_data_d;
   strb_t       w_strb_q,  w_strb_d;
   logic        bvalid_q,  bvalid_d;
   resp_t       bresp_q,   bresp_d;

   // Read-side registers
   logic        rvalid_q,  rvalid_d;
   resp_t       rresp_q,   rresp_d;
   logic        rd_ok_q,   rd_ok_d;

   // Combinational
   logic             w_aw_hs;
   logic             w_w_hs;
   logic             w_commit;
   word_t            w_aw_addr;
   word_t            w_w_data;
   strb_t            w_w_strb;
   logic             w_aw_aligned;
   logic             w_ar_aligned;
   logic             w_wr_ok;
   logic             w_rd_ok;
   logic             w_ar_hs;
   logic             w_ram_we;
   logic [IDX_W-1:0] w_wr_idx;
   logic [IDX_W-1:0] w_rd_idx;
   logic [31:0]      w_ram_rdata;

`ifdef DATA_RAM_ALIGN_CHECK_EN
   assign w_aw_aligned = (w_aw_addr[1:0] == 2'b00);
   assign w_ar_aligned = (araddr[1:0] == 2'b00);
`else
   assign w_aw_aligned = 1'b1;
   assign w_ar_aligned = 1'b1;
`endif

   assign awready = !aw_full_q;
   assign wready  = !w_full_q;
   assign arready = !rvalid_q || rready;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign rvalid  = rvalid_q;
   assign rresp   = rresp_q;
   assign rdata   = rd_ok_q ? w_ram_rdata : 32'h0;

   // Write channel: accept AW/W independently, commit when both are
   // available and the response slot is free, bypassing the holding
   // registers so a new pair can commit every cycle.
   always_comb begin
      w_aw_hs   = awvalid && !aw_full_q;
      w_w_hs    = wvalid && !w_full_q;
      w_aw_addr = aw_full_q ? aw_addr_q : awaddr;
      w_w_data  = w_full_q  ? w_data_q  : wdata;
      w_w_strb  = w_full_q  ? w_strb_q  : wstrb;
      w_commit  = (aw_full_q || w_aw_hs) && (w_full_q || w_w_hs) &&
                  (!bvalid_q || bready);
      w_wr_ok   = inrange(w_aw_addr, BASE, SIZE) && w_aw_aligned;
      w_ram_we  = w_commit && w_wr_ok;
      w_wr_idx  = IDX_W'((w_aw_addr - BASE) >> 2);

      aw_full_d = aw_full_q;
      aw_addr_d = aw_addr_q;
      w_full_d  = w_full_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;

      if (w_aw_hs) begin
         aw_full_d = 1'b1;
         aw_addr_d = awaddr;
      end
      if (w_w_hs) begin
         w_full_d = 1'b1;
         w_data_d = wdata;
         w_strb_d = wstrb;
      end
      if (bvalid_q && bready) begin
         bvalid_d = 1'b0;
      end
      if (w_commit) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = w_wr_ok ? OKAY : SLVERR;
      end
   end

   // Read channel: the RAM read register doubles as the rdata holding
   // register, so it is only enabled on an AR handshake.
   always_comb begin
      w_ar_hs  = arvalid && (!rvalid_q || rready);
      w_rd_ok  = inrange(araddr, BASE, SIZE) && w_ar_aligned;
      w_rd_idx = IDX_W'((araddr - BASE) >> 2);

      rvalid_d = rvalid_q;
      rresp_d  = rresp_q;
      rd_ok_d  = rd_ok_q;

      if (rvalid_q && rready) begin
         rvalid_d = 1'b0;
      end
      if (w_ar_hs) begin
         rvalid_d = 1'b1;
         rresp_d  = w_rd_ok ? OKAY : SLVERR;
         rd_ok_d  = w_rd_ok;
      end
   end

   // Control and holding-register state; RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         aw_full_q <= 1'b0;
         aw_addr_q <= '0;
         w_full_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= OKAY;
         rvalid_q  <= 1'b0;
         rresp_q   <= OKAY;
         rd_ok_q   <= 1'b0;
      end else begin
         aw_full_q <= aw_full_d;
         aw_addr_q <= aw_addr_d;
         w_full_q  <= w_full_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rd_ok_q   <= rd_ok_d;
      end
   end

   data_ram_responder_ram_sdp_bytewrite #(
      .DEPTH (WORDS),
      .AW    (IDX_W)
   ) u_ram (
      .clk   (clk),
      .we    (w_ram_we),
      .waddr (w_wr_idx),
      .wbe   (w_w_strb),
      .wdata (w_w_data),
      .re    (w_ar_hs),
      .raddr (w_rd_idx),
      .rdata (w_ram_rdata)
   );

endmodule
`default_nettype wire

// File: tb/tb_data_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_ram_responder
// Description : Directed self-checking bench for data_ram_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_ram_responder;

   localparam logic [1:0] R_OKAY   = 2'b00;
   localparam logic [1:0] R_SLVERR = 2'b10;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   int checks   = 0;
   int failures = 0;

   data_ram_responder dut (
      .clk     (clk),
      .reset   (reset),
      .awaddr  (awaddr),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wvalid  (wvalid),
      .wready  (wready),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready),
      .araddr  (araddr),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rvalid  (rvalid),
      .rready  (rready)
   );

   always #5 clk = ~clk;

   // Single write, both channels in one cycle, bready high.
   // Starts and ends just after a falling edge.
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic bv, output logic [1:0] br);
      awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      bv = bvalid; br = bresp;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Single read with rready high.
   task automatic rd(input logic [31:0] a, output logic rv, output logic [31:0] d,
                     output logic [1:0] rr);
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      arvalid = 1'b0;
      rv = rvalid; d = rdata; rr = rresp;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
      awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      checks++; if (awready !== 1'b1) begin failures++; $display("FAIL reset_awready got=%b exp=1", awready); end
      checks++; if (wready  !== 1'b1) begin failures++; $display("FAIL reset_wready got=%b exp=1", wready); end
      checks++; if (arready !== 1'b1) begin failures++; $display("FAIL reset_arready got=%b exp=1", arready); end
      checks++; if (bvalid  !== 1'b0) begin failures++; $display("FAIL reset_bvalid got=%b exp=0", bvalid); end
      checks++; if (bresp   !== R_OKAY) begin failures++; $display("FAIL reset_bresp got=%b exp=00", bresp); end
      checks++; if (rvalid  !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
      checks++; if (rresp   !== R_OKAY) begin failures++; $display("FAIL reset_rresp got=%b exp=00", rresp); end
      checks++; if (rdata   !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
   endtask

   task automatic test_basic_rw();
      logic bv; logic [1:0] br; logic rv; logic [31:0] d; logic [1:0] rr;
      wr(32'h1004, 32'hDEADBEEF, 4'hF, bv, br);
      checks++; if (bv !== 1'b1 || br !== R_OKAY) begin failures++; $display("FAIL basic_bresp got=%b/%b exp=1/00", bv, br); end
      checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL basic_bvalid_clear got=%b exp=0", bvalid); end
      rd(32'h1004, rv, d, rr);
      checks++; if (rv !== 1'b1 || d !== 32'hDEADBEEF || rr !== R_OKAY) begin failures++; $display("FAIL basic_read got=%b/%h/%b exp=1/deadbeef/00", rv, d, rr); end
      checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL basic_rvalid_clear got=%b exp=0", rvalid); end
   endtask

   task automatic test_strobe();
      logic bv; logic [1:0] br; logic rv; logic [31:0] d; logic [1:0] rr;
      wr(32'h1008, 32'h11223344, 4'hF, bv, br);
      wr(32'h1008, 32'hAABBCCDD, 4'b0101, bv, br);
      checks++; if (br !== R_OKAY) begin failures++; $display("FAIL strobe_bresp got=%b exp=00", br); end
      rd(32'h1008, rv, d, rr);
      checks++; if (d !== 32'h11BB33DD) begin failures++; $display("FAIL strobe_merge got=%h exp=11bb33dd", d); end
      wr(32'h1008, 32'hFFFFFFFF, 4'h0, bv, br);
      checks++; if (bv !== 1'b1 || br !== R_OKAY) begin failures++; $display("FAIL strobe0_bresp got=%b/%b exp=1/00", bv, br); end
      rd(32'h1008, rv, d, rr);
      checks++; if (d !== 32'h11BB33DD) begin failures++; $display("FAIL strobe0_nowrite got=%h exp=11bb33dd", d); end
   endtask

   task automatic test_backpressure();
      logic rv; logic [31:0] d; logic [1:0] rr;
      // First write commits but its response is held by bready=0.
      awaddr = 32'h100C; awvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
      @(posedge clk); @(negedge clk);
      awvalid = 1'b0; wdata = 32'h66;   // W of the second write, ahead of its AW
      checks++; if (bvalid !== 1'b1) begin failures++; $display("FAIL bp_bvalid0 got=%b exp=1", bvalid); end
      @(posedge clk); @(negedge clk);
      wvalid = 1'b0;
      checks++; if (wready !== 1'b0) begin failures++; $display("FAIL bp_wready_full got=%b exp=0", wready); end
      @(posedge clk); @(negedge clk);
      checks++; if (bvalid !== 1'b1 || wready !== 1'b0) begin failures++; $display("FAIL bp_hold got=%b/%b exp=1/0", bvalid, wready); end
      awaddr = 32'h1014; awvalid = 1'b1;
      @(posedge clk); @(negedge clk);
      awvalid = 1'b0;
      checks++; if (awready !== 1'b0 || wready !== 1'b0) begin failures++; $display("FAIL bp_both_full got=%b/%b exp=0/0", awready, wready); end
      checks++; if (bvalid !== 1'b1 || bresp !== R_OKAY) begin failures++; $display("FAIL bp_bvalid_stall got=%b/%b exp=1/00", bvalid, bresp); end
      @(posedge clk); @(negedge clk);
      bready = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++; if (bvalid !== 1'b1 || awready !== 1'b1 || wready !== 1'b1) begin failures++; $display("FAIL bp_second_resp got=%b/%b/%b exp=1/1/1", bvalid, awready, wready); end
      @(posedge clk); @(negedge clk);
      checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", bvalid); end
      rd(32'h100C, rv, d, rr);
      checks++; if (d !== 32'h55) begin failures++; $display("FAIL bp_first_data got=%h exp=00000055", d); end
      rd(32'h1014, rv, d, rr);
      checks++; if (d !== 32'h66) begin failures++; $display("FAIL bp_second_data got=%h exp=00000066", d); end
   endtask

   task automatic test_range();
      logic bv; logic [1:0] br; logic rv; logic [31:0] d; logic [1:0] rr;
      wr(32'h1FFC, 32'hCAFEF00D, 4'hF, bv, br);
      checks++; if (br !== R_OKAY) begin failures++; $display("FAIL range_top_ok got=%b exp=00", br); end
      wr(32'h0FFC, 32'h12345678, 4'hF, bv, br);
      checks++; if (bv !== 1'b1 || br !== R_SLVERR) begin failures++; $display("FAIL range_below got=%b/%b exp=1/10", bv, br); end
      wr(32'h2000, 32'h87654321, 4'hF, bv, br);
      checks++; if (bv !== 1'b1 || br !== R_SLVERR) begin failures++; $display("FAIL range_above got=%b/%b exp=1/10", bv, br); end
      rd(32'h2000, rv, d, rr);
      checks++; if (rv !== 1'b1 || rr !== R_SLVERR || d !== 32'h0) begin failures++; $display("FAIL range_read got=%b/%b/%h exp=1/10/0", rv, rr, d); end
      rd(32'h1FFC, rv, d, rr);
      checks++; if (rr !== R_OKAY || d !== 32'hCAFEF00D) begin failures++; $display("FAIL range_top_keep got=%b/%h exp=00/cafef00d", rr, d); end
      rd(32'h1000 - 32'h4, rv, d, rr);
      checks++; if (rr !== R_SLVERR || d !== 32'h0) begin failures++; $display("FAIL range_read_below got=%b/%h exp=10/0", rr, d); end
   endtask

   task automatic test_back_to_back_reads();
      logic bv; logic [1:0] br;
      wr(32'h1000, 32'hA0A0A0A0, 4'hF, bv, br);
      araddr = 32'h1000; arvalid = 1'b1; rready = 1'b1;
      #1;
      checks++; if (arready !== 1'b1) begin failures++; $display("FAIL b2b_arready0 got=%b exp=1", arready); end
      @(posedge clk); @(negedge clk);
      araddr = 32'h1004; rready = 1'b0;
      #1;
      checks++; if (rvalid !== 1'b1 || rdata !== 32'hA0A0A0A0) begin failures++; $display("FAIL b2b_first got=%b/%h exp=1/a0a0a0a0", rvalid, rdata); end
      checks++; if (arready !== 1'b0) begin failures++; $display("FAIL b2b_arready_stall got=%b exp=0", arready); end
      @(posedge clk); @(negedge clk);
      checks++; if (rvalid !== 1'b1 || rdata !== 32'hA0A0A0A0) begin failures++; $display("FAIL b2b_stable got=%b/%h exp=1/a0a0a0a0", rvalid, rdata); end
      rready = 1'b1;
      #1;
      checks++; if (arready !== 1'b1) begin failures++; $display("FAIL b2b_arready_go got=%b exp=1", arready); end
      @(posedge clk); @(negedge clk);
      araddr = 32'h1008;
      checks++; if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/deadbeef", rvalid, rdata); end
      @(posedge clk); @(negedge clk);
      arvalid = 1'b0;
      checks++; if (rvalid !== 1'b1 || rdata !== 32'h11BB33DD) begin failures++; $display("FAIL b2b_third got=%b/%h exp=1/11bb33dd", rvalid, rdata); end
      @(posedge clk); @(negedge clk);
      checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", rvalid); end
   endtask

   task automatic test_back_to_back_writes();
      logic rv; logic [31:0] d; logic [1:0] rr;
      awaddr = 32'h1020; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      @(posedge clk); @(negedge clk);
      awaddr = 32'h1024; wdata = 32'h2;
      checks++; if (bvalid !== 1'b1 || awready !== 1'b1 || wready !== 1'b1) begin failures++; $display("FAIL bbw_first got=%b/%b/%b exp=1/1/1", bvalid, awready, wready); end
      @(posedge clk); @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      checks++; if (bvalid !== 1'b1) begin failures++; $display("FAIL bbw_second got=%b exp=1", bvalid); end
      @(posedge clk); @(negedge clk);
      checks++; if (bvalid !== 1'b0) begin failures++; $display("FAIL bbw_drain got=%b exp=0", bvalid); end
      rd(32'h1020, rv, d, rr);
      checks++; if (d !== 32'h1) begin failures++; $display("FAIL bbw_data0 got=%h exp=1", d); end
      rd(32'h1024, rv, d, rr);
      checks++; if (d !== 32'h2) begin failures++; $display("FAIL bbw_data1 got=%h exp=2", d); end
   endtask

   task automatic test_collision();
      logic bv; logic [1:0] br; logic rv; logic [31:0] d; logic [1:0] rr;
      wr(32'h1010, 32'h1, 4'hF, bv, br);
      awaddr = 32'h1010; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      araddr = 32'h1010; arvalid = 1'b1; rready = 1'b1;
      @(posedge clk); @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      checks++; if (rvalid !== 1'b1 || rdata !== 32'h1) begin failures++; $display("FAIL coll_read_first got=%b/%h exp=1/1", rvalid, rdata); end
      checks++; if (bvalid !== 1'b1 || bresp !== R_OKAY) begin failures++; $display("FAIL coll_bresp got=%b/%b exp=1/00", bvalid, bresp); end
      @(posedge clk); @(negedge clk);
      rd(32'h1010, rv, d, rr);
      checks++; if (d !== 32'h2) begin failures++; $display("FAIL coll_after got=%h exp=2", d); end
`ifdef DATA_RAM_ALIGN_CHECK_EN
      rd(32'h1011, rv, d, rr);
      checks++; if (rr !== R_SLVERR || d !== 32'h0) begin failures++; $display("FAIL align_read got=%b/%h exp=10/0", rr, d); end
      wr(32'h1012, 32'h77, 4'hF, bv, br);
      checks++; if (br !== R_SLVERR) begin failures++; $display("FAIL align_write got=%b exp=10", br); end
      rd(32'h1010, rv, d, rr);
      checks++; if (d !== 32'h2) begin failures++; $display("FAIL align_nowrite got=%h exp=2", d); end
`else
      rd(32'h1011, rv, d, rr);
      checks++; if (rr !== R_OKAY || d !== 32'h2) begin failures++; $display("FAIL misalign_read got=%b/%h exp=00/2", rr, d); end
`endif
   endtask

   task automatic test_reset_midflight();
      logic rv; logic [31:0] d; logic [1:0] rr;
      awaddr = 32'h1030; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      @(posedge clk); @(negedge clk);
      wvalid = 1'b0; awaddr = 32'h1034;   // second AW waits for its W
      araddr = 32'h1030; arvalid = 1'b1; rready = 1'b0;
      @(posedge clk); @(negedge clk);
      awvalid = 1'b0; arvalid = 1'b0;
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      checks++; if (bvalid !== 1'b0 || rvalid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b/%b exp=0/0", bvalid, rvalid); end
      checks++; if (awready !== 1'b1 || wready !== 1'b1 || rdata !== 32'h0) begin failures++; $display("FAIL rst_mid_ready got=%b/%b/%h exp=1/1/0", awready, wready, rdata); end
      rd(32'h1030, rv, d, rr);
      checks++; if (d !== 32'h9) begin failures++; $display("FAIL rst_mid_ram got=%h exp=9", d); end
      rd(32'h1010, rv, d, rr);
      checks++; if (d !== 32'h2) begin failures++; $display("FAIL rst_mid_keep got=%h exp=2", d); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic_rw();
      test_strobe();
      test_backpressure();
      test_range();
      test_back_to_back_reads();
      test_back_to_back_writes();
      test_collision();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
